// File: rtl/card_hand_bank_if.sv
// Deal handshake bundle for card_hand_bank: four-phase req/ack plus the
// card source selection that travels with the request.
interface card_hand_bank_if #(
    parameter int HW = 1
) ();
    logic          deal_req;
    logic [HW-1:0] deal_hand;
    logic          force_en;
    logic [3:0]    force_card;
    logic          deal_ack;
    logic          deal_err;

    modport master (
        output deal_req, deal_hand, force_en, force_card,
        input  deal_ack, deal_err
    );

    modport slave (
        input  deal_req, deal_hand, force_en, force_card,
        output deal_ack, deal_err
    );
endinterface

// File: rtl/card_hand_bank.sv
// card_hand_bank: NUM_HANDS hands of CARDS_PER_HAND baccarat card slots.
// A deal lands in the next empty slot of the requested hand. The card comes
// from a free-running 1..13 counter, or from force_card when force_en is set.
// Each hand keeps a running mod-10 score. Every slot drives a seven-segment code.
module card_hand_bank #(
    parameter  int NUM_HANDS      = 2,
    parameter  int CARDS_PER_HAND = 3,
    localparam int HW             = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW             = $clog2(CARDS_PER_HAND + 1)
) (
    input  logic                                    slow_clock,
    input  logic                                    resetb,
    card_hand_bank_if.slave                         bus,
    input  logic [NUM_HANDS-1:0]                    clear_hand,
    output logic [4*NUM_HANDS*CARDS_PER_HAND-1:0]   cards,
    output logic [7*NUM_HANDS*CARDS_PER_HAND-1:0]   segs,
    output logic [4*NUM_HANDS-1:0]                  scores,
    output logic [CW*NUM_HANDS-1:0]                 counts,
    output logic [NUM_HANDS-1:0]                    full
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_ctr;
    logic [HW-1:0]  r_hand;
    logic [3:0]     r_val;
    logic           r_ack, r_err;
    logic           w_ack_nxt, w_err_nxt;

    logic [NUM_HANDS-1:0] w_hit;   // WRITE cycle aimed at this hand
    logic [NUM_HANDS-1:0] w_wr;    // this hand actually takes the card
    logic                 w_val_ok;

    // Blank for empty and illegal codes. Segment order is g..a, active low.
    function automatic logic [6:0] f_seg(input logic [3:0] c);
        case (c)
            4'd1:    f_seg = 7'b0001000;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            4'd10:   f_seg = 7'b1000000;
            4'd11:   f_seg = 7'b1100001;
            4'd12:   f_seg = 7'b0011000;
            4'd13:   f_seg = 7'b0001001;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    // Tens and face cards score zero.
    function automatic logic [3:0] f_scoreval(input logic [3:0] c);
        f_scoreval = (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    assign bus.deal_ack = r_ack;
    assign bus.deal_err = r_err;
    assign w_val_ok     = (r_val != 4'd0) && (r_val <= 4'd13);
    assign w_wr         = w_hit & ~full & ~clear_hand & {NUM_HANDS{w_val_ok}};

    // Card counter cycles 1..13 and never yields 0 or 14..15.
    always_ff @(posedge slow_clock) begin
        if (!resetb)               r_ctr <= 4'd1;
        else if (r_ctr == 4'd13)   r_ctr <= 4'd1;
        else                       r_ctr <= r_ctr + 4'd1;
    end

    // Capture the target hand and the card value when a request is accepted.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_hand <= '0;
            r_val  <= '0;
        end else if (r_state == S_IDLE && bus.deal_req) begin
            r_hand <= bus.deal_hand;
            r_val  <= bus.force_en ? bus.force_card : r_ctr;
        end
    end

    // Handshake state, registered ack and registered error flag.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next state. In ACK, ack rises one cycle after entry, so it appears two
    // edges after acceptance. It then falls at the edge that sees req low.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                w_ack_nxt = 1'b0;
                w_err_nxt = 1'b0;
                if (bus.deal_req) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // The card goes into at most one hand.
                w_err_nxt   = ~(|w_wr);
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (!r_ack) begin
                    w_ack_nxt = 1'b1;
                end else if (!bus.deal_req) begin
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        logic [3:0]    r_card [CARDS_PER_HAND];
        logic [CW-1:0] r_cnt;
        logic [3:0]    r_score;
        logic [4:0]    w_sum;
        logic [4:0]    w_mod;

        assign w_hit[h] = (r_state == S_WRITE) && (r_hand == HW'(h));
        assign full[h]  = (r_cnt == CW'(CARDS_PER_HAND));
        // Add in 5 bits, then fold back into 0..9.
        assign w_sum    = {1'b0, r_score} + {1'b0, f_scoreval(r_val)};
        assign w_mod    = (w_sum >= 5'd10) ? (w_sum - 5'd10) : w_sum;

        assign scores[h*4 +: 4]   = r_score;
        assign counts[h*CW +: CW] = r_cnt;

        // Slot storage. Clearing this hand beats a write to it in the same cycle.
        always_ff @(posedge slow_clock) begin
            if (!resetb || clear_hand[h]) begin
                r_cnt   <= '0;
                r_score <= '0;
                for (int s = 0; s < CARDS_PER_HAND; s++) r_card[s] <= '0;
            end else if (w_wr[h]) begin
                for (int s = 0; s < CARDS_PER_HAND; s++)
                    if (r_cnt == CW'(s)) r_card[s] <= r_val;
                r_cnt   <= r_cnt + CW'(1);
                r_score <= w_mod[3:0];
            end
        end

        for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
            assign cards[(h*CARDS_PER_HAND+s)*4 +: 4] = r_card[s];
            assign segs[(h*CARDS_PER_HAND+s)*7 +: 7]  = f_seg(r_card[s]);
        end
    end

endmodule

// File: tb/tb_card_hand_bank.sv
// Scoreboard bench for card_hand_bank. The stimulus drives deals and pushes the
// expected post-deal state onto a queue. The monitor pops and compares when
// deal_ack rises.
module tb_card_hand_bank;
    localparam int NH  = 2;
    localparam int CPH = 3;
    localparam int HW  = 1;
    localparam int CW  = 2;

    typedef struct {
        logic                  err;
        logic [4*NH*CPH-1:0]   cards;
        logic [7*NH*CPH-1:0]   segs;
        logic [4*NH-1:0]       scores;
        logic [CW*NH-1:0]      counts;
        logic [NH-1:0]         full;
    } item_t;

    logic clk = 1'b0;
    logic resetb;
    logic [NH-1:0]         clear_hand;
    logic [4*NH*CPH-1:0]   cards;
    logic [7*NH*CPH-1:0]   segs;
    logic [4*NH-1:0]       scores;
    logic [CW*NH-1:0]      counts;
    logic [NH-1:0]         full;

    card_hand_bank_if #(.HW(HW)) bus ();

    card_hand_bank #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH)) dut (
        .slow_clock(clk), .resetb(resetb), .bus(bus), .clear_hand(clear_hand),
        .cards(cards), .segs(segs), .scores(scores), .counts(counts), .full(full)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    ncyc  = 0;       // edges since reset release
    item_t sb[$];
    int    mc [NH][CPH];    // model: dealt cards per hand
    int    mn [NH];         // model: cards held per hand
    logic  ack_q = 1'b0;

    always @(posedge clk) begin
        if (!resetb) ncyc <= 0;
        else         ncyc <= ncyc + 1;
    end

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            1: return 7'b0001000;  2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;
            7: return 7'b1111000;  8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b1000000; 11: return 7'b1100001; 12: return 7'b0011000;
            13: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic void model_clear(input int h);
        mn[h] = 0;
        for (int s = 0; s < CPH; s++) mc[h][s] = 0;
    endfunction

    function automatic item_t snap(input logic e);
        item_t it;
        it.err = e; it.cards = '0; it.segs = '1; it.scores = '0; it.counts = '0; it.full = '0;
        for (int h = 0; h < NH; h++) begin
            int sum = 0;
            for (int s = 0; s < mn[h]; s++) begin
                it.cards[(h*CPH+s)*4 +: 4] = 4'(mc[h][s]);
                it.segs[(h*CPH+s)*7 +: 7]  = seg_of(mc[h][s]);
                sum += (mc[h][s] <= 9) ? mc[h][s] : 0;
            end
            it.scores[h*4 +: 4]   = 4'(sum % 10);
            it.counts[h*CW +: CW] = CW'(mn[h]);
            it.full[h]            = (mn[h] == CPH);
        end
        return it;
    endfunction

    function automatic void chk_state(input string tag, input item_t e);
        chk({tag, "_cards"},  128'(cards),  128'(e.cards));
        chk({tag, "_segs"},   128'(segs),   128'(e.segs));
        chk({tag, "_scores"}, 128'(scores), 128'(e.scores));
        chk({tag, "_counts"}, 128'(counts), 128'(e.counts));
        chk({tag, "_full"},   128'(full),   128'(e.full));
    endfunction

    // Monitor: on each rising ack, compare the DUT against the oldest expectation.
    always @(negedge clk) begin
        if (bus.deal_ack && !ack_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(1), 128'(0));
            end else begin
                item_t e;
                e = sb.pop_front();
                chk("mon_err", 128'(bus.deal_err), 128'(e.err));
                chk_state("mon", e);
            end
        end
        ack_q = bus.deal_ack;
    end

    task automatic do_reset(input int edges);
        @(negedge clk);
        resetb = 1'b0; bus.deal_req = 1'b0; clear_hand = '0;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        for (int h = 0; h < NH; h++) model_clear(h);
        chk("rst_ack", 128'(bus.deal_ack), 128'(0));
        chk("rst_err", 128'(bus.deal_err), 128'(0));
        chk_state("rst", snap(1'b0));
        resetb = 1'b1;
    endtask

    // One full handshake. clr is applied on the WRITE edge. When rst_ack is set,
    // reset is asserted while in ACK.
    task automatic deal(input int h, input bit fen, input int fc, input logic [NH-1:0] clr,
                        input int hold, input bit rst_ack);
        int val;
        bit e;
        @(negedge clk);
        bus.deal_hand = HW'(h); bus.force_en = fen; bus.force_card = 4'(fc); bus.deal_req = 1'b1;
        val = fen ? fc : (ncyc % 13) + 1;
        @(posedge clk);                      // acceptance
        @(negedge clk); clear_hand = clr;
        @(posedge clk);                      // WRITE edge
        @(negedge clk); clear_hand = '0;
        for (int k = 0; k < NH; k++) if (clr[k]) model_clear(k);
        if (h >= NH || clr[h] || mn[h] == CPH || val < 1 || val > 13) e = 1'b1;
        else begin mc[h][mn[h]] = val; mn[h]++; e = 1'b0; end
        sb.push_back(snap(e));
        chk("ack_early", 128'(bus.deal_ack), 128'(0));
        @(negedge clk);
        chk("ack_lat", 128'(bus.deal_ack), 128'(1));
        if (rst_ack) begin
            resetb = 1'b0; bus.deal_req = 1'b0;
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < NH; k++) model_clear(k);
            chk("mid_rst_ack", 128'(bus.deal_ack), 128'(0));
            chk_state("mid_rst", snap(1'b0));
            resetb = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_hold", 128'(bus.deal_ack), 128'(1));
        end
        bus.deal_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ack_fall", 128'(bus.deal_ack), 128'(0));
        chk("err_fall", 128'(bus.deal_err), 128'(0));
    endtask

    task automatic idle_clear(input logic [NH-1:0] m);
        @(negedge clk); clear_hand = m;
        @(posedge clk);
        @(negedge clk); clear_hand = '0;
        for (int k = 0; k < NH; k++) if (m[k]) model_clear(k);
    endtask

    initial begin
        resetb = 1'b0; clear_hand = '0;
        bus.deal_req = 1'b0; bus.deal_hand = '0; bus.force_en = 1'b0; bus.force_card = '0;
        for (int h = 0; h < NH; h++) model_clear(h);
        do_reset(2);

        // Directed forced deals
        deal(0, 1, 7, '0, 0, 0);
        deal(0, 1, 13, '0, 0, 0);
        deal(1, 1, 9, '0, 0, 0);
        deal(1, 1, 5, '0, 0, 0);
        deal(1, 1, 8, '0, 0, 0);
        chk("h0_score", 128'(scores[3:0]), 128'(7));
        chk("h0_count", 128'(counts[1:0]), 128'(2));
        chk("h0_slots", 128'(cards[11:0]), 128'(12'h0D7));
        chk("h1_score", 128'(scores[7:4]), 128'(2));
        chk("h1_full",  128'(full[1]), 128'(1));
        chk("h1_segs",  128'(segs[41:21]), 128'({7'b0000000, 7'b0010010, 7'b0010000}));
        // Overflow into full hand 1
        deal(1, 1, 4, '0, 0, 0);
        chk("ovf_score", 128'(scores[7:4]), 128'(2));
        // Long hold
        deal(0, 1, 2, '0, 5, 0);
        // Clear collision on hand 0
        deal(0, 1, 3, 2'b01, 0, 0);
        chk("clr_h0_count", 128'(counts[1:0]), 128'(0));
        chk("clr_h1_count", 128'(counts[3:2]), 128'(3));
        // Counter source, with the request on the third edge after release
        do_reset(2);
        @(negedge clk);
        deal(0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            idle_clear(2'b11);
            deal($urandom_range(0, NH-1), 0, 0, '0, $urandom_range(0, 2), 0);
        end
        // Reset in ACK, then a normal deal
        deal(1, 1, 6, '0, 0, 1);
        deal(1, 1, 11, '0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [NH-1:0] clr;
            int fc;
            if ($urandom_range(0, 3) == 0) idle_clear(NH'($urandom_range(1, (1 << NH) - 1)));
            clr = ($urandom_range(0, 5) == 0) ? NH'($urandom_range(0, (1 << NH) - 1)) : '0;
            fc  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 13);
            for (int w = 0; w < $urandom_range(0, 3); w++) @(negedge clk);
            deal($urandom_range(0, NH-1), 1'($urandom_range(0, 1)), fc, clr,
                 $urandom_range(0, 3), 0);
        end

        @(negedge clk);
        chk_state("final", snap(1'b0));
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
